btn_event_gen: RTL and testbench

Per-button press-event classifier. It sits directly downstream of the push-button debouncing flip-flops and consumes their debounced levels plus the same slow clock-enable tick (4 Hz, one `clk` cycle wide). It converts each level into single-cycle event pulses: press, short click, long press, auto-repeat and release. The air-conditioner control FSMs use these pulses for mode, temperature and fan-speed keys.

---
 rtl/btn_event_gen.sv | 135 +++++++++++++
 tb/tb_btn_event_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_gen.sv
// Per-button press-event classifier: turns debounced levels into press/click/long/repeat/release pulses.
// One independent FSM plus tick counter per button; all outputs registered.

module btn_event_fsm #(
    parameter int LONG_TICKS   = 8,
    parameter int REPEAT_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_en,
    input  logic btn,
    output logic press,
    output logic click,
    output logic long_p,
    output logic rpt,
    output logic rel,
    output logic held
);
    localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CW   = $clog2(MAXT + 1);

    typedef enum logic [1:0] {S_LOCK, S_IDLE, S_SHORT, S_LONG} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            press_n, click_n, long_n, rpt_n, rel_n, held_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_LOCK;
            cnt    <= '0;
            press  <= 1'b0;
            click  <= 1'b0;
            long_p <= 1'b0;
            rpt    <= 1'b0;
            rel    <= 1'b0;
            held   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            press  <= press_n;
            click  <= click_n;
            long_p <= long_n;
            rpt    <= rpt_n;
            rel    <= rel_n;
            held   <= held_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        press_n = 1'b0;
        click_n = 1'b0;
        long_n  = 1'b0;
        rpt_n   = 1'b0;
        rel_n   = 1'b0;
        case (state)
            // A button held through reset must be seen released before it can fire.
            S_LOCK: if (!btn) state_n = S_IDLE;
            S_IDLE: if (btn) begin
                state_n = S_SHORT;
                cnt_n   = '0;
                press_n = 1'b1;
            end
            S_SHORT: begin
                if (!btn) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    click_n = 1'b1;
                    rel_n   = 1'b1;
                end else if (tick_en) begin
                    if (cnt == CW'(LONG_TICKS - 1)) begin
                        state_n = S_LONG;
                        cnt_n   = '0;
                        long_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            S_LONG: begin
                if (!btn) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    rel_n   = 1'b1;
                end else if (tick_en) begin
                    if (cnt == CW'(REPEAT_TICKS - 1)) begin
                        cnt_n = '0;
                        rpt_n = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = S_LOCK;
        endcase
        held_n = (state_n == S_SHORT) || (state_n == S_LONG);
    end
endmodule

module btn_event_gen #(
    parameter int N_BTN        = 5,
    parameter int LONG_TICKS   = 8,
    parameter int REPEAT_TICKS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] click_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] held
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_event_fsm #(
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_fsm (
            .clk    (clk),
            .reset  (reset),
            .tick_en(tick_en),
            .btn    (btn_db[i]),
            .press  (press_pulse[i]),
            .click  (click_pulse[i]),
            .long_p (long_pulse[i]),
            .rpt    (repeat_pulse[i]),
            .rel    (release_pulse[i]),
            .held   (held[i])
        );
    end
endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen: segment table, hand-written corner sequences and random stimulus vs a tick-count model.

module tb_btn_event_gen;
    localparam int N   = 4;
    localparam int LT  = 8;
    localparam int RT  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         tick_en;
    logic [N-1:0] btn_db;
    logic [N-1:0] press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held;

    btn_event_gen #(.N_BTN(N), .LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_en      (tick_en),
        .btn_db       (btn_db),
        .press_pulse  (press_pulse),
        .click_pulse  (click_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .release_pulse(release_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ph     = 0;

    // Reference: per button, "locked" until seen released, "active" while held, n = ticks counted since press.
    bit           m_lock [N];
    bit           m_act  [N];
    int           m_n    [N];
    logic [N-1:0] e_p, e_c, e_l, e_r, e_rl, e_h;
    logic [N-1:0] a_p, a_c, a_l, a_r, a_rl;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_lock[i] = 1'b1;
            m_act[i]  = 1'b0;
            m_n[i]    = 0;
        end
        e_p = '0; e_c = '0; e_l = '0; e_r = '0; e_rl = '0; e_h = '0;
    endtask

    task automatic model_step(input logic [N-1:0] b, input logic t);
        e_p = '0; e_c = '0; e_l = '0; e_r = '0; e_rl = '0;
        for (int i = 0; i < N; i++) begin
            if (m_lock[i]) begin
                if (!b[i]) m_lock[i] = 1'b0;
            end else if (!m_act[i]) begin
                if (b[i]) begin
                    e_p[i]  = 1'b1;
                    m_act[i] = 1'b1;
                    m_n[i]  = 0;
                end
            end else if (!b[i]) begin
                e_rl[i]  = 1'b1;
                e_c[i]   = (m_n[i] < LT);
                m_act[i] = 1'b0;
            end else if (t) begin
                m_n[i]++;
                if (m_n[i] == LT) e_l[i] = 1'b1;
                else if (m_n[i] > LT && ((m_n[i] - LT) % RT) == 0) e_r[i] = 1'b1;
            end
            e_h[i] = m_act[i];
        end
    endtask

    task automatic clr_acc();
        a_p = '0; a_c = '0; a_l = '0; a_r = '0; a_rl = '0;
    endtask

    // One clock: drive at negedge, update model at posedge, compare 1 time unit later.
    task automatic do_cycle(input logic [N-1:0] b);
        logic t;
        @(negedge clk);
        btn_db  = b;
        t       = ((ph % 10) == 9);
        tick_en = t;
        ph++;
        @(posedge clk);
        if (reset) model_reset();
        else       model_step(b, t);
        #1;
        chk("press", press_pulse, e_p);
        chk("click", click_pulse, e_c);
        chk("long", long_pulse, e_l);
        chk("repeat", repeat_pulse, e_r);
        chk("release", release_pulse, e_rl);
        chk("held", held, e_h);
        a_p |= press_pulse; a_c |= click_pulse; a_l |= long_pulse;
        a_r |= repeat_pulse; a_rl |= release_pulse;
    endtask

    typedef struct {
        logic [N-1:0] btn;
        int           cyc;
        logic [N-1:0] p, c, l, r, rl, h;
    } seg_t;

    seg_t tbl [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tk;
        tbl[0]  = '{4'b0000,  5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0010,  1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        tbl[2]  = '{4'b0010, 30, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        tbl[3]  = '{4'b0000,  1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        tbl[4]  = '{4'b0000,  3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0100,  1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        tbl[6]  = '{4'b0100, 78, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        tbl[7]  = '{4'b0100, 10, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
        tbl[8]  = '{4'b0100, 20, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100};
        tbl[9]  = '{4'b0100,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        tbl[10] = '{4'b0100, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100};
        tbl[11] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        tbl[12] = '{4'b0000,  5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        reset = 1'b1; tick_en = 1'b0; btn_db = '0;
        model_reset();
        clr_acc();

        // Button held through reset: locked out until released once.
        repeat (3) do_cycle(4'b0001);
        reset = 1'b0;
        clr_acc();
        repeat (200) do_cycle(4'b0001);
        chk("lock_pulses", a_p | a_c | a_l | a_r | a_rl, 4'b0000);
        chk("lock_held", held, 4'b0000);
        do_cycle(4'b0000);
        do_cycle(4'b0001);
        chk("unlock_press", press_pulse, 4'b0001);
        do_cycle(4'b0001);
        chk("unlock_press_1cyc", press_pulse, 4'b0000);
        do_cycle(4'b0000);

        // Segment table: short click on bit 1, long + repeats on bit 2.
        ph = 0;
        foreach (tbl[k]) begin
            clr_acc();
            repeat (tbl[k].cyc) do_cycle(tbl[k].btn);
            chk($sformatf("seg%0d_press", k), a_p, tbl[k].p);
            chk($sformatf("seg%0d_click", k), a_c, tbl[k].c);
            chk($sformatf("seg%0d_long", k), a_l, tbl[k].l);
            chk($sformatf("seg%0d_repeat", k), a_r, tbl[k].r);
            chk($sformatf("seg%0d_release", k), a_rl, tbl[k].rl);
            chk($sformatf("seg%0d_held", k), held, tbl[k].h);
        end

        // Press on a tick (uncounted), release exactly on the would-be long tick.
        while ((ph % 10) != 9) do_cycle(4'b0000);
        do_cycle(4'b1000);
        chk("tickpress_press", press_pulse, 4'b1000);
        clr_acc();
        repeat (79) do_cycle(4'b1000);
        chk("rel_on_tick_nolong_before", a_l, 4'b0000);
        do_cycle(4'b0000);
        chk("rel_on_tick_click", click_pulse, 4'b1000);
        chk("rel_on_tick_release", release_pulse, 4'b1000);
        chk("rel_on_tick_long", long_pulse, 4'b0000);

        // Same press-on-tick, but hold: long fires on the 9th tick seen.
        while ((ph % 10) != 9) do_cycle(4'b0000);
        do_cycle(4'b1000);
        clr_acc();
        repeat (79) do_cycle(4'b1000);
        chk("tickpress_nolong_8th", a_l, 4'b0000);
        do_cycle(4'b1000);
        chk("tickpress_long_9th", long_pulse, 4'b1000);
        do_cycle(4'b0000);
        chk("tickpress_noclick", click_pulse, 4'b0000);

        // Simultaneous press of bits 0 and 2; bit 0 released after 2 ticks.
        if ((ph % 10) == 9) do_cycle(4'b0000);
        do_cycle(4'b0101);
        chk("dual_press", press_pulse, 4'b0101);
        tk = 0;
        while (tk < 2) begin
            do_cycle(4'b0101);
            tk += int'(tick_en);
        end
        do_cycle(4'b0100);
        tk += int'(tick_en);
        chk("dual_click0", click_pulse, 4'b0001);
        chk("dual_release0", release_pulse, 4'b0001);
        for (int c = 0; c < 200 && !long_pulse[2]; c++) begin
            do_cycle(4'b0100);
            tk += int'(tick_en);
        end
        chk("dual_long2", long_pulse, 4'b0100);
        chk_int("dual_long2_ticks", tk, LT);

        // Asynchronous reset mid-cycle while bit 2 is long.
        repeat (5) do_cycle(4'b0100);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_held", held, 4'b0000);
        chk("async_pulses", press_pulse | click_pulse | long_pulse | repeat_pulse | release_pulse, 4'b0000);
        model_reset();
        repeat (3) do_cycle(4'b0100);
        reset = 1'b0;
        clr_acc();
        repeat (50) do_cycle(4'b0100);
        chk("postrst_pulses", a_p | a_c | a_l | a_r | a_rl, 4'b0000);
        chk("postrst_held", held, 4'b0000);
        do_cycle(4'b0000);
        do_cycle(4'b0100);
        chk("postrst_press", press_pulse, 4'b0100);

        // Random level changes, every cycle checked against the model.
        begin
            logic [N-1:0] b;
            b = 4'b0100;
            for (int c = 0; c < 4000; c++) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 149) == 0) b[i] = ~b[i];
                do_cycle(b);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
